// File: rtl/uart_datunpkg_module_pkg.sv
// uart_datunpkg_module_pkg: shared UART constants, frame geometry and unpacker FSM states.
package uart_datunpkg_module_pkg;
  localparam int unsigned FRECLK = 50_000_000;
  localparam logic [19:0] UART_BAUDRATE = 20'd115200;
  localparam logic [1:0] NONE_CHECK = 2'd0;
  localparam logic [1:0] ODD_CHECK = 2'd1;
  localparam logic [1:0] EVEN_CHECK = 2'd2;
  localparam logic [4:0] FRM_LEN = 5'd16;
  typedef enum logic [1:0] {IDLE, REQ, LATCH, CHECK} state_t;
endpackage

// File: rtl/UART_rx_interface.sv
// UART_rx_interface: 16x-oversampled UART receiver feeding a 16-entry byte FIFO.
module UART_rx_interface
  import uart_datunpkg_module_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        RD_Req_sig,
  input  logic [19:0] BaudRate,
  input  logic [1:0]  FrameCheck,
  output logic [7:0]  FIFO_RD_Dat,
  output logic        Empty_sig,
  input  logic        RX_pin
);
  logic [1:0]  sync_q;
  logic [25:0] acc_q, acc_d;
  logic [26:0] sum;
  logic        tick, rx, busy_q, busy_d, par_q, par_d, wr, full, par_ok;
  logic [3:0]  cnt_q, cnt_d, bit_q, bit_d, last;
  logic [7:0]  dat_q, dat_d, rd_dat_q;
  logic [4:0]  wp_q, rp_q;
  logic [7:0]  mem [16];
  // fractional baud accumulator avoids a runtime divide by BaudRate
  assign sum = {1'b0, acc_q} + 27'({BaudRate, 4'b0});
  assign tick = sum >= 27'(FRECLK);
  assign acc_d = tick ? 26'(sum - 27'(FRECLK)) : sum[25:0];
  assign rx = sync_q[1];
  assign last = FrameCheck == NONE_CHECK ? 4'd9 : 4'd10;
  assign par_ok = FrameCheck == ODD_CHECK ? ^{dat_q, par_q} : FrameCheck == EVEN_CHECK ? ~^{dat_q, par_q} : 1'b1;
  assign Empty_sig = wp_q == rp_q;
  assign full = wp_q[4] != rp_q[4] && wp_q[3:0] == rp_q[3:0];
  assign FIFO_RD_Dat = rd_dat_q;
  always_comb begin
    busy_d = busy_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    dat_d = dat_q;
    par_d = par_q;
    wr = 1'b0;
    if (!busy_q) begin
      if (tick && !rx) begin
        busy_d = 1'b1;
        cnt_d = 4'd0;
        bit_d = 4'd0;
      end
    end else if (tick) begin
      cnt_d = cnt_q + 4'd1;
      bit_d = cnt_q == 4'd15 ? bit_q + 4'd1 : bit_q;
      if (cnt_q == 4'd7) begin
        if (bit_q == last) begin
          busy_d = 1'b0;
          wr = rx && par_ok;
        end else if (bit_q == 4'd0) busy_d = !rx;
        else if (bit_q <= 4'd8) dat_d = {rx, dat_q[7:1]};
        else par_d = rx;
      end
    end
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      sync_q <= 2'b11;
      acc_q <= '0;
      busy_q <= 1'b0;
      cnt_q <= '0;
      bit_q <= '0;
      dat_q <= '0;
      par_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      rd_dat_q <= '0;
    end else begin
      sync_q <= {sync_q[0], RX_pin};
      acc_q <= acc_d;
      busy_q <= busy_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      dat_q <= dat_d;
      par_q <= par_d;
      if (wr && !full) wp_q <= wp_q + 5'd1;
      if (RD_Req_sig && !Empty_sig) begin
        rd_dat_q <= mem[rp_q[3:0]];
        rp_q <= rp_q + 5'd1;
      end
    end
  always_ff @(posedge CLK)
    if (wr && !full) mem[wp_q[3:0]] <= dat_q;
endmodule

// File: rtl/uart_datunpkg_module.sv
// uart_datunpkg_module: unpacks 16-byte UART frames into eight 11-bit channels,
// committing only complete well-formed frames and dropping stalled ones.
module uart_datunpkg_module
  import uart_datunpkg_module_pkg::*;
#(
  parameter logic [19:0] BAUDRATE = UART_BAUDRATE,
  parameter logic [1:0]  FRAMECHK = NONE_CHECK,
  parameter logic [23:0] GAP_CYC  = 24'd50_000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        RX_pin,
  output logic [87:0] Dat_Out,
  output logic        Dat_Vld,
  output logic        Frm_Err
);
  state_t      st_q, st_d;
  logic        rd_req, empty, latch, commit, timeout;
  logic        err_q, err_d, vld_q, vld_d, ferr_q, ferr_d;
  logic [7:0]  rd_dat;
  logic [4:0]  idx_q, idx_d;
  logic [6:0]  base;
  logic [23:0] gap_q, gap_d;
  logic [87:0] sh_q, sh_d, dat_q, dat_d;
  UART_rx_interface u_rx (
    .CLK(CLK),
    .RSTn(RSTn),
    .RD_Req_sig(rd_req),
    .BaudRate(BAUDRATE),
    .FrameCheck(FRAMECHK),
    .FIFO_RD_Dat(rd_dat),
    .Empty_sig(empty),
    .RX_pin(RX_pin)
  );
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) st_q <= IDLE;
    else st_q <= st_d;
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:  st_d = empty ? IDLE : REQ;
      REQ:   st_d = LATCH;
      LATCH: st_d = CHECK;
      default: st_d = IDLE;
    endcase
  end
  always_comb rd_req = st_q == REQ;
  assign latch = st_q == LATCH;
  assign commit = st_q == CHECK && idx_q == FRM_LEN;
  // a byte landing in the same cycle as the gap limit keeps the frame alive
  assign timeout = idx_q != 5'd0 && gap_q >= GAP_CYC && !latch;
  assign base = 7'(idx_q[3:1]) * 7'd11;
  always_comb begin
    sh_d = sh_q;
    if (latch && !idx_q[0]) sh_d[7'(base + 7'd8) +: 3] = rd_dat[2:0];
    if (latch && idx_q[0]) sh_d[base +: 8] = rd_dat;
    idx_d = latch ? idx_q + 5'd1 : (commit || timeout) ? 5'd0 : idx_q;
    err_d = (latch && !idx_q[0] && |rd_dat[7:3]) ? 1'b1 : (commit || timeout) ? 1'b0 : err_q;
    gap_d = latch ? 24'd0 : idx_q == 5'd0 ? gap_q : gap_q + 24'(gap_q < GAP_CYC);
    dat_d = commit && !err_q ? sh_q : dat_q;
    vld_d = commit && !err_q;
    ferr_d = (commit && err_q) || timeout;
  end
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      idx_q <= '0;
      err_q <= 1'b0;
      gap_q <= '0;
      sh_q <= '0;
      dat_q <= '0;
      vld_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      err_q <= err_d;
      gap_q <= gap_d;
      sh_q <= sh_d;
      dat_q <= dat_d;
      vld_q <= vld_d;
      ferr_q <= ferr_d;
    end
  assign Dat_Out = dat_q;
  assign Dat_Vld = vld_q;
  assign Frm_Err = ferr_q;
endmodule

// File: tb/tb_uart_datunpkg_module.sv
// tb_uart_datunpkg_module: directed serial frames (good, malformed, stalled, reset mid-frame).
module tb_uart_datunpkg_module;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        RX_pin = 1'b1;
  logic [87:0] Dat_Out;
  logic        Dat_Vld, Frm_Err;
  int total = 0, bad = 0, vld_cnt = 0, ferr_cnt = 0, both_cnt = 0;
  localparam int BIT = 1000;
  localparam logic [87:0] EXP_A = {11'h7FF, 11'h123, 11'h70F, 11'h0F0, 11'h2AA, 11'h155, 11'h001, 11'h400};
  localparam logic [87:0] EXP_B = {11'h001, 11'h002, 11'h004, 11'h008, 11'h010, 11'h020, 11'h040, 11'h080};
  localparam logic [87:0] EXP_C = {11'h5A5, 11'h25A, 11'h5A5, 11'h25A, 11'h5A5, 11'h25A, 11'h5A5, 11'h25A};
  localparam logic [87:0] EXP_D = {11'h000, 11'h7FF, 11'h3C3, 11'h43C, 11'h111, 11'h666, 11'h799, 11'h0AB};
  uart_datunpkg_module #(.BAUDRATE(20'd1_000_000), .FRAMECHK(2'd0), .GAP_CYC(24'd3000)) dut (
    .CLK(CLK), .RSTn(RSTn), .RX_pin(RX_pin), .Dat_Out(Dat_Out), .Dat_Vld(Dat_Vld), .Frm_Err(Frm_Err)
  );
  always #10 CLK = ~CLK;
  always @(negedge CLK) begin
    if (Dat_Vld) vld_cnt++;
    if (Frm_Err) ferr_cnt++;
    if (Dat_Vld && Frm_Err) both_cnt++;
  end
  task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b);
    RX_pin = 1'b0;
    #BIT;
    for (int i = 0; i < 8; i++) begin
      RX_pin = b[i];
      #BIT;
    end
    RX_pin = 1'b1;
    #BIT;
  endtask
  task automatic send_frame(input logic [87:0] v, input int nbytes, input int bad_idx, input logic [7:0] bad_val);
    logic [10:0] ch;
    logic [7:0]  b;
    for (int i = 0; i < nbytes; i++) begin
      ch = v[11*(i/2) +: 11];
      b = (i % 2 == 0) ? {5'b0, ch[10:8]} : ch[7:0];
      if (i == bad_idx) b = bad_val;
      send_byte(b);
    end
    #(BIT * 2);
  endtask
  initial begin
    repeat (5) @(negedge CLK);
    chk("rst_dout", Dat_Out, 88'd0);
    chk("rst_vld", 88'(Dat_Vld), 88'd0);
    chk("rst_ferr", 88'(Frm_Err), 88'd0);
    RSTn = 1'b1;
    #(BIT * 3);
    send_frame(EXP_A, 16, -1, 8'h00);
    chk("a_vld", 88'(vld_cnt), 88'd1);
    chk("a_ferr", 88'(ferr_cnt), 88'd0);
    chk("a_dout", Dat_Out, EXP_A);
    chk("a_ch0", 88'(Dat_Out[10:0]), 88'h400);
    chk("a_ch7", 88'(Dat_Out[87:77]), 88'h7FF);
    send_frame(EXP_B, 16, 4, 8'h0B);
    chk("bad_vld", 88'(vld_cnt), 88'd1);
    chk("bad_ferr", 88'(ferr_cnt), 88'd1);
    chk("bad_dout", Dat_Out, EXP_A);
    send_frame(EXP_B, 16, -1, 8'h00);
    chk("b_vld", 88'(vld_cnt), 88'd2);
    chk("b_ferr", 88'(ferr_cnt), 88'd1);
    chk("b_dout", Dat_Out, EXP_B);
    send_frame(EXP_C, 7, -1, 8'h00);
    chk("gap_early", 88'(ferr_cnt), 88'd1);
    #(BIT * 70);
    chk("gap_ferr", 88'(ferr_cnt), 88'd2);
    chk("gap_vld", 88'(vld_cnt), 88'd2);
    #(BIT * 70);
    chk("gap_once", 88'(ferr_cnt), 88'd2);
    send_frame(EXP_C, 16, -1, 8'h00);
    chk("c_vld", 88'(vld_cnt), 88'd3);
    chk("c_dout", Dat_Out, EXP_C);
    send_frame(EXP_B, 9, -1, 8'h00);
    @(negedge CLK);
    RSTn = 1'b0;
    repeat (10) @(negedge CLK);
    RSTn = 1'b1;
    #(BIT * 3);
    chk("rstmid_vld", 88'(vld_cnt), 88'd3);
    chk("rstmid_ferr", 88'(ferr_cnt), 88'd2);
    chk("rstmid_dout", Dat_Out, 88'd0);
    send_frame(EXP_D, 16, -1, 8'h00);
    chk("d_vld", 88'(vld_cnt), 88'd4);
    chk("d_ferr", 88'(ferr_cnt), 88'd2);
    chk("d_dout", Dat_Out, EXP_D);
    chk("no_overlap", 88'(both_cnt), 88'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
